ram_dma_copy: RTL and testbench
===============================

Name: ram_dma_copy

Overview:
Single-port DMA initiator that drives one port of the 64KB dual-port block RAM (1-cycle read latency, write-first) to copy or fill a byte block. A CPU-side register interface supplies the transfer and pulses start; the engine owns the RAM port until done. The other RAM port stays with the CPU, so the CPU keeps running during the transfer.

Parameters:
DATA_WIDTH, 8, RAM word width.
ADDR_WIDTH, 16, RAM address width; all pointers and the length use this width.

Ports:
clk  in  1  system clock; RAM port clock is tied to the same net.
reset  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse; latches cfg_* and begins a transfer when idle.
abort  in  1  stops the transfer at the next byte boundary.
cfg_mode  in  1  0 = copy, 1 = fill.
cfg_src  in  ADDR_WIDTH  copy source start address.
cfg_dst  in  ADDR_WIDTH  destination start address.
cfg_len  in  ADDR_WIDTH  byte count; 0 means no transfer.
cfg_fill  in  DATA_WIDTH  fill value.
busy  out  1  high from the cycle after an accepted start until done.
done  out  1  one-cycle pulse at transfer end, including abort and len=0.
remaining  out  ADDR_WIDTH  bytes not yet written.
ram_addr  out  ADDR_WIDTH  to RAM addr port.
ram_we  out  1  to RAM write-enable port.
ram_wdata  out  DATA_WIDTH  to RAM data-in port.
ram_rdata  in  DATA_WIDTH  from RAM data-out port; valid the cycle after the address is presented with ram_we=0.

Behaviour:
- Reset applies on the clk edge and wins over every other input. It forces state IDLE and drives busy=0, done=0, remaining=0, ram_addr=0, ram_we=0, ram_wdata=0. Reset during a transfer abandons it with no done pulse; bytes already written stay written.
- RAM outputs are combinational decodes of registered state and pointers. No combinational path from ram_rdata to ram_addr or ram_we.
- States:
  - IDLE. On start with cfg_len!=0: latch cfg_*, set src_ptr, dst_ptr, remaining=cfg_len, busy=1, then go to READ (copy) or WRITE (fill). On start with cfg_len=0: pulse done next cycle, busy stays 0.
  - READ (copy only). ram_addr=src_ptr, ram_we=0, src_ptr+1. Then WRITE.
  - WRITE. ram_addr=dst_ptr, ram_we=1, ram_wdata=ram_rdata in copy mode or fill value in fill mode. dst_ptr+1, remaining-1. If remaining becomes 0 or abort is high, go to FINISH. Otherwise go to READ (copy) or stay in WRITE (fill).
  - FINISH. busy=0, done=1 for one cycle, then IDLE.
- Throughput: copy is 2 cycles/byte, fill is 1 cycle/byte. Copy of N bytes gives done N*2+1 cycles after start; fill gives N+1.
- Pointers wrap modulo 2**ADDR_WIDTH; 0xFFFF+1 = 0x0000, with no error.
- abort sampled in READ: the current byte still completes in WRITE, then FINISH. abort in IDLE is ignored. remaining shows the bytes not copied.
- start while busy is ignored; cfg_* changes while busy have no effect.
- Overlapping forward copy with dst>src repeats the source pattern; this is defined behaviour (see the optional feature).

Optional Feature:
RAM_DMA_REVERSE_EN.
- Defined: adds input cfg_reverse (1 bit), latched at start. When set, pointers start at cfg_src+cfg_len-1 and cfg_dst+cfg_len-1 and decrement, with the same wrap rules. This makes overlapping copies with dst>src safe.
- Undefined: port absent; pointers always increment.

Decomposition:
- Package ram_dma_pkg:
  - state enum (IDLE, READ, WRITE, FINISH), 2 bits.
  - MODE_COPY/MODE_FILL constants.
- One sub-module, ram_dma_ptr: loadable ADDR_WIDTH pointer with increment, and decrement under RAM_DMA_REVERSE_EN. Instantiated twice (src, dst).

Test Plan:
1. Preload RAM[0x1000..0x1003]=11,22,33,44. Copy src=0x1000 dst=0x2000 len=4 -> RAM[0x2000..0x2003]=11,22,33,44; done exactly 9 cycles after start; busy high 8 cycles.
2. Fill dst=0xFFFE len=4 val=0xA5 -> writes 0xFFFE, 0xFFFF, 0x0000, 0x0001 in consecutive cycles; RAM[0x0002] unchanged.
3. start with len=0 -> no ram_we ever, busy stays 0, done pulses once the next cycle.
4. Copy len=100, assert abort during the 10th READ -> exactly 10 bytes written, remaining=90 at done, done pulses once.
5. Assert reset in the middle of a 50-byte fill -> next cycle busy=0, ram_we=0, remaining=0, no done pulse. A new start afterwards runs normally.
6. With RAM_DMA_REVERSE_EN: RAM[0x10..0x13]=1,2,3,4, copy src=0x10 dst=0x12 len=4 reverse=1 -> RAM[0x12..0x15]=1,2,3,4.

Source files
------------

// File: rtl/ram_dma_pkg.sv
// ram_dma_pkg: shared types and constants for the ram_dma_copy engine.
//   dma_state_e : engine state encoding (IDLE, READ, WRITE, FINISH), 2 bits.
//   MODE_COPY / MODE_FILL : values of cfg_mode.
// Optional feature macro used across the bundle: RAM_DMA_REVERSE_EN.
package ram_dma_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } dma_state_e;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/ram_dma_copy_if.sv
// ram_dma_copy_if: groups the CPU-side register/handshake signals and the
// DMA-owned RAM port into one bundle.
//   master : the DMA engine view (drives busy/done/remaining and the RAM port).
//   slave  : the CPU + RAM view (drives start/abort/cfg_* and ram_rdata).
// With RAM_DMA_REVERSE_EN defined, cfg_reverse is added to the bundle.
interface ram_dma_copy_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
);
  logic                  start;
  logic                  abort;
  logic                  cfg_mode;
  logic [ADDR_WIDTH-1:0] cfg_src;
  logic [ADDR_WIDTH-1:0] cfg_dst;
  logic [ADDR_WIDTH-1:0] cfg_len;
  logic [DATA_WIDTH-1:0] cfg_fill;
`ifdef RAM_DMA_REVERSE_EN
  logic                  cfg_reverse;
`endif
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] remaining;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

`ifdef RAM_DMA_REVERSE_EN
  modport master (
    input  start, abort, cfg_mode, cfg_src, cfg_dst, cfg_len, cfg_fill, cfg_reverse, ram_rdata,
    output busy, done, remaining, ram_addr, ram_we, ram_wdata
  );
  modport slave (
    output start, abort, cfg_mode, cfg_src, cfg_dst, cfg_len, cfg_fill, cfg_reverse, ram_rdata,
    input  busy, done, remaining, ram_addr, ram_we, ram_wdata
  );
`else
  modport master (
    input  start, abort, cfg_mode, cfg_src, cfg_dst, cfg_len, cfg_fill, ram_rdata,
    output busy, done, remaining, ram_addr, ram_we, ram_wdata
  );
  modport slave (
    output start, abort, cfg_mode, cfg_src, cfg_dst, cfg_len, cfg_fill, ram_rdata,
    input  busy, done, remaining, ram_addr, ram_we, ram_wdata
  );
`endif

endinterface

// File: rtl/ram_dma_ptr.sv
// ram_dma_ptr: loadable address pointer, wraps modulo 2**ADDR_WIDTH.
//   clk, reset : clock, synchronous active-high reset (pointer -> 0)
//   load       : load load_val (wins over step)
//   load_val   : start address
//   step       : advance one position
//   down       : (RAM_DMA_REVERSE_EN only) step decrements instead of increments
//   ptr        : current pointer value
module ram_dma_ptr #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_val,
  input  logic                  step,
`ifdef RAM_DMA_REVERSE_EN
  input  logic                  down,
`endif
  output logic [ADDR_WIDTH-1:0] ptr
);
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (load) begin
      ptr_d = load_val;
    end else if (step) begin
`ifdef RAM_DMA_REVERSE_EN
      ptr_d = down ? (ptr_q - ONE) : (ptr_q + ONE);
`else
      ptr_d = ptr_q + ONE;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/ram_dma_copy.sv
// ram_dma_copy: single-port DMA engine that copies or fills a byte block
// through one port of a dual-port block RAM (1-cycle read latency).
//   clk   : system clock (RAM port shares it)
//   reset : synchronous active-high reset
//   bus   : ram_dma_copy_if.master
//           CPU side  : start, abort, cfg_mode/src/dst/len/fill -> busy, done, remaining
//           RAM side  : ram_addr, ram_we, ram_wdata -> ram_rdata
// Copy costs 2 cycles/byte (READ then WRITE), fill 1 cycle/byte (WRITE only).
// Optional: RAM_DMA_REVERSE_EN adds cfg_reverse, running both pointers downward
// from the block end so overlapping copies with dst>src are safe.
module ram_dma_copy
  import ram_dma_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
) (
  input logic            clk,
  input logic            reset,
  ram_dma_copy_if.master bus
);
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  dma_state_e            state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  mode_q, mode_d;
  logic                  abort_q, abort_d;
  logic [ADDR_WIDTH-1:0] remaining_q, remaining_d;
  logic [DATA_WIDTH-1:0] fill_q, fill_d;
`ifdef RAM_DMA_REVERSE_EN
  logic                  rev_q, rev_d;
`endif

  logic                  ptr_load, src_step, dst_step;
  logic [ADDR_WIDTH-1:0] src_init, dst_init, src_ptr, dst_ptr;

  // Pointer start addresses: block start, or block end when running reversed.
  always_comb begin
    src_init = bus.cfg_src;
    dst_init = bus.cfg_dst;
`ifdef RAM_DMA_REVERSE_EN
    if (bus.cfg_reverse) begin
      src_init = bus.cfg_src + bus.cfg_len - ONE;
      dst_init = bus.cfg_dst + bus.cfg_len - ONE;
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    mode_d      = mode_q;
    abort_d     = abort_q;
    remaining_d = remaining_q;
    fill_d      = fill_q;
`ifdef RAM_DMA_REVERSE_EN
    rev_d       = rev_q;
`endif
    ptr_load    = 1'b0;
    src_step    = 1'b0;
    dst_step    = 1'b0;
    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (bus.start) begin
          if (bus.cfg_len != '0) begin
            ptr_load    = 1'b1;
            remaining_d = bus.cfg_len;
            mode_d      = bus.cfg_mode;
            fill_d      = bus.cfg_fill;
            busy_d      = 1'b1;
`ifdef RAM_DMA_REVERSE_EN
            rev_d       = bus.cfg_reverse;
`endif
            state_d     = (bus.cfg_mode == MODE_FILL) ? WRITE : READ;
          end else begin
            // Empty transfer: report completion without ever owning the RAM.
            done_d  = 1'b1;
            state_d = FINISH;
          end
        end
      end
      READ: begin
        src_step = 1'b1;
        // Abort seen during the read is remembered so this byte still lands.
        if (bus.abort) abort_d = 1'b1;
        state_d = WRITE;
      end
      WRITE: begin
        dst_step    = 1'b1;
        remaining_d = remaining_q - ONE;
        if (remaining_q == ONE || bus.abort || abort_q) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = FINISH;
        end else begin
          state_d = (mode_q == MODE_FILL) ? WRITE : READ;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mode_q      <= MODE_COPY;
      abort_q     <= 1'b0;
      remaining_q <= '0;
      fill_q      <= '0;
`ifdef RAM_DMA_REVERSE_EN
      rev_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mode_q      <= mode_d;
      abort_q     <= abort_d;
      remaining_q <= remaining_d;
      fill_q      <= fill_d;
`ifdef RAM_DMA_REVERSE_EN
      rev_q       <= rev_d;
`endif
    end
  end

  ram_dma_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_src_ptr (
    .clk      (clk),
    .reset    (reset),
    .load     (ptr_load),
    .load_val (src_init),
    .step     (src_step),
`ifdef RAM_DMA_REVERSE_EN
    .down     (rev_q),
`endif
    .ptr      (src_ptr)
  );

  ram_dma_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_dst_ptr (
    .clk      (clk),
    .reset    (reset),
    .load     (ptr_load),
    .load_val (dst_init),
    .step     (dst_step),
`ifdef RAM_DMA_REVERSE_EN
    .down     (rev_q),
`endif
    .ptr      (dst_ptr)
  );

  // RAM port is a pure decode of state and pointers; only write data may
  // follow ram_rdata, so there is no loop from read data back to the address.
  always_comb begin
    bus.ram_addr  = '0;
    bus.ram_we    = 1'b0;
    bus.ram_wdata = '0;
    case (state_q)
      READ: begin
        bus.ram_addr = src_ptr;
      end
      WRITE: begin
        bus.ram_addr  = dst_ptr;
        bus.ram_we    = 1'b1;
        bus.ram_wdata = (mode_q == MODE_FILL) ? fill_q : bus.ram_rdata;
      end
      default: ;
    endcase
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.remaining = remaining_q;

endmodule

// File: tb/tb_ram_dma_copy.sv
module tb_ram_dma_copy;
  localparam int DW = 8;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [DW-1:0] mem [0:65535];
  logic [AW-1:0] wlog [$];

  ram_dma_copy_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  ram_dma_copy #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Write-first block RAM port with 1-cycle read latency.
  always @(posedge clk) begin
    if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_rdata     <= bus.ram_wdata;
      wlog.push_back(bus.ram_addr);
    end else begin
      bus.ram_rdata <= mem[bus.ram_addr];
    end
    if (bus.done) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want summary");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a configuration with a one-cycle start; returns in cycle 1.
  task automatic kick(input logic mode, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                      input logic [AW-1:0] len, input logic [DW-1:0] fill);
    bus.cfg_mode = mode;
    bus.cfg_src  = src;
    bus.cfg_dst  = dst;
    bus.cfg_len  = len;
    bus.cfg_fill = fill;
    bus.start    = 1'b1;
    step();
    bus.start    = 1'b0;
  endtask

  // Bounded wait for done; cyc counts cycles since start (start cycle = 0).
  task automatic run_to_done(input int limit, output int cyc, output int busy_cycles);
    cyc = 1;
    busy_cycles = 0;
    while (bus.done !== 1'b1 && cyc < limit) begin
      if (bus.busy === 1'b1) busy_cycles++;
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.remaining !== 16'h0) begin errors++; $display("FAIL reset_remaining got %h want 0", bus.remaining); end
    checks++; if (bus.ram_addr !== 16'h0) begin errors++; $display("FAIL reset_addr got %h want 0", bus.ram_addr); end
    checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", bus.ram_we); end
    checks++; if (bus.ram_wdata !== 8'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", bus.ram_wdata); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_copy();
    int cyc, bc;
    logic [DW-1:0] exp [4];
    exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) mem[16'h1000 + i] = exp[i];
    wlog.delete();
    kick(1'b0, 16'h1000, 16'h2000, 16'd4, 8'h00);
    run_to_done(40, cyc, bc);
    checks++; if (cyc != 9) begin errors++; $display("FAIL copy_done_latency got %0d want 9", cyc); end
    checks++; if (bc != 8) begin errors++; $display("FAIL copy_busy_cycles got %0d want 8", bc); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL copy_busy_at_done got %b want 0", bus.busy); end
    checks++; if (bus.remaining !== 16'd0) begin errors++; $display("FAIL copy_remaining got %0d want 0", bus.remaining); end
    checks++; if (wlog.size() != 4) begin errors++; $display("FAIL copy_write_count got %0d want 4", wlog.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[16'h2000 + i] !== exp[i]) begin
        errors++; $display("FAIL copy_data[%0d] got %h want %h", i, mem[16'h2000 + i], exp[i]);
      end
    end
    step();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL copy_done_pulse got %b want 0", bus.done); end
  endtask

  task automatic test_fill_wrap();
    int cyc, bc;
    logic [AW-1:0] exp_a [4];
    exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    mem[16'h0002] = 8'h5A;
    // abort while idle must not poison the next transfer
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    wlog.delete();
    kick(1'b1, 16'h0000, 16'hFFFE, 16'd4, 8'hA5);
    run_to_done(40, cyc, bc);
    checks++; if (cyc != 5) begin errors++; $display("FAIL fill_done_latency got %0d want 5", cyc); end
    checks++; if (wlog.size() != 4) begin errors++; $display("FAIL fill_write_count got %0d want 4", wlog.size()); end
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      checks++;
      if (wlog[i] !== exp_a[i]) begin errors++; $display("FAIL fill_addr[%0d] got %h want %h", i, wlog[i], exp_a[i]); end
      checks++;
      if (mem[exp_a[i]] !== 8'hA5) begin errors++; $display("FAIL fill_data[%0d] got %h want a5", i, mem[exp_a[i]]); end
    end
    checks++; if (mem[16'h0002] !== 8'h5A) begin errors++; $display("FAIL fill_untouched got %h want 5a", mem[16'h0002]); end
    step();
  endtask

  task automatic test_len0();
    int dc0;
    dc0 = done_cnt;
    wlog.delete();
    kick(1'b0, 16'h1000, 16'h3000, 16'd0, 8'h00);
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL len0_done got %b want 1", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL len0_busy got %b want 0", bus.busy); end
    step();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL len0_done_pulse got %b want 0", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL len0_busy_after got %b want 0", bus.busy); end
    step();
    checks++; if (wlog.size() != 0) begin errors++; $display("FAIL len0_writes got %0d want 0", wlog.size()); end
    checks++; if (done_cnt - dc0 != 1) begin errors++; $display("FAIL len0_done_count got %0d want 1", done_cnt - dc0); end
  endtask

  task automatic test_abort();
    int cyc, reads, dc0;
    for (int i = 0; i < 100; i++) mem[16'h3000 + i] = 8'(i + 1);
    mem[16'h400A] = 8'hEE;
    dc0 = done_cnt;
    wlog.delete();
    kick(1'b0, 16'h3000, 16'h4000, 16'd100, 8'h00);
    cyc = 1;
    reads = 0;
    while (bus.done !== 1'b1 && cyc < 300) begin
      if (bus.busy === 1'b1 && bus.ram_we === 1'b0) begin
        reads++;
        if (reads == 10) bus.abort = 1'b1;
      end
      step();
      bus.abort = 1'b0;
      cyc++;
    end
    checks++; if (cyc != 21) begin errors++; $display("FAIL abort_done_latency got %0d want 21", cyc); end
    checks++; if (bus.remaining !== 16'd90) begin errors++; $display("FAIL abort_remaining got %0d want 90", bus.remaining); end
    checks++; if (wlog.size() != 10) begin errors++; $display("FAIL abort_write_count got %0d want 10", wlog.size()); end
    checks++; if (mem[16'h4009] !== 8'd10) begin errors++; $display("FAIL abort_last_byte got %h want 0a", mem[16'h4009]); end
    checks++; if (mem[16'h400A] !== 8'hEE) begin errors++; $display("FAIL abort_untouched got %h want ee", mem[16'h400A]); end
    step();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_done_pulse got %b want 0", bus.done); end
    checks++; if (done_cnt - dc0 != 1) begin errors++; $display("FAIL abort_done_count got %0d want 1", done_cnt - dc0); end
  endtask

  task automatic test_reset_mid();
    int cyc, bc, dc0;
    dc0 = done_cnt;
    wlog.delete();
    kick(1'b1, 16'h0000, 16'h5000, 16'd50, 8'hC3);
    repeat (10) step();
    reset = 1'b1;
    step();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
    checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL rstmid_we got %b want 0", bus.ram_we); end
    checks++; if (bus.remaining !== 16'd0) begin errors++; $display("FAIL rstmid_remaining got %0d want 0", bus.remaining); end
    reset = 1'b0;
    repeat (5) step();
    checks++; if (done_cnt != dc0) begin errors++; $display("FAIL rstmid_no_done got %0d want 0", done_cnt - dc0); end
    checks++; if (wlog.size() != 11) begin errors++; $display("FAIL rstmid_writes got %0d want 11", wlog.size()); end
    checks++; if (mem[16'h500A] !== 8'hC3) begin errors++; $display("FAIL rstmid_kept got %h want c3", mem[16'h500A]); end
    checks++; if (mem[16'h500B] !== 8'h00) begin errors++; $display("FAIL rstmid_beyond got %h want 00", mem[16'h500B]); end
    kick(1'b1, 16'h0000, 16'h6000, 16'd3, 8'h3C);
    run_to_done(40, cyc, bc);
    checks++; if (cyc != 4) begin errors++; $display("FAIL rstmid_restart_latency got %0d want 4", cyc); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem[16'h6000 + i] !== 8'h3C) begin errors++; $display("FAIL rstmid_restart_data[%0d] got %h want 3c", i, mem[16'h6000 + i]); end
    end
    step();
  endtask

  task automatic test_back_to_back();
    int cyc;
    wlog.delete();
    kick(1'b0, 16'h1000, 16'h7000, 16'd2, 8'h00);
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 40) begin
      if (cyc == 2) begin
        // a second start and new config while busy must be ignored
        bus.cfg_mode = 1'b1;
        bus.cfg_dst  = 16'h7100;
        bus.cfg_len  = 16'd5;
        bus.cfg_fill = 8'h77;
        bus.start    = 1'b1;
      end
      step();
      bus.start = 1'b0;
      cyc++;
    end
    checks++; if (cyc != 5) begin errors++; $display("FAIL b2b_done_latency got %0d want 5", cyc); end
    checks++; if (wlog.size() != 2) begin errors++; $display("FAIL b2b_write_count got %0d want 2", wlog.size()); end
    checks++; if (mem[16'h7000] !== 8'h11) begin errors++; $display("FAIL b2b_data0 got %h want 11", mem[16'h7000]); end
    checks++; if (mem[16'h7001] !== 8'h22) begin errors++; $display("FAIL b2b_data1 got %h want 22", mem[16'h7001]); end
    checks++; if (mem[16'h7100] !== 8'h00) begin errors++; $display("FAIL b2b_ignored got %h want 00", mem[16'h7100]); end
    step();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got %b want 0", bus.busy); end
  endtask

`ifdef RAM_DMA_REVERSE_EN
  task automatic test_reverse();
    int cyc, bc;
    for (int i = 0; i < 4; i++) mem[16'h0010 + i] = 8'(i + 1);
    bus.cfg_reverse = 1'b1;
    kick(1'b0, 16'h0010, 16'h0012, 16'd4, 8'h00);
    bus.cfg_reverse = 1'b0;
    run_to_done(40, cyc, bc);
    checks++; if (cyc != 9) begin errors++; $display("FAIL rev_done_latency got %0d want 9", cyc); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[16'h0012 + i] !== 8'(i + 1)) begin errors++; $display("FAIL rev_data[%0d] got %h want %h", i, mem[16'h0012 + i], 8'(i + 1)); end
    end
    step();
  endtask
`endif

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.cfg_mode = 1'b0;
    bus.cfg_src  = '0;
    bus.cfg_dst  = '0;
    bus.cfg_len  = '0;
    bus.cfg_fill = '0;
`ifdef RAM_DMA_REVERSE_EN
    bus.cfg_reverse = 1'b0;
`endif
    test_reset();
    test_copy();
    test_fill_wrap();
    test_len0();
    test_abort();
    test_reset_mid();
    test_back_to_back();
`ifdef RAM_DMA_REVERSE_EN
    test_reverse();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
